mosbius_cfg_loader: RTL and testbench
=====================================

Name: mosbius_cfg_loader

Overview:
- Digital configuration front-end that drives the analog switch matrix of the mini-MOSbius array.
- Receives a serial configuration word over a 3-wire SPI-style interface (mode 0, MSB first) from the dedicated input pins.
- Reads back the currently applied word on sdo_o.
- Commits a new word with a break-before-make sequence: all switches open for BBM_CYCLES clocks, then the new pattern.

Parameters:
- CFG_BITS, 32: number of switch-control bits; width of the shift register and of cfg_o.
- BBM_CYCLES, 4: number of clk cycles cfg_o is held all-zero before a new word is applied; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- sck_i  input  1  serial clock from pin; asynchronous to clk.
- sdi_i  input  1  serial data in from pin; asynchronous.
- cs_n_i  input  1  chip select from pin, active-low; asynchronous.
- sdo_o  output  1  serial readback data.
- cfg_o  output  CFG_BITS  switch controls; 1 = switch closed.
- cfg_busy_o  output  1  high while the break-before-make sequence runs.
- cfg_done_o  output  1  one-cycle pulse when a new word is applied.
- cfg_err_o  output  1  sticky flag for a rejected transaction.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cfg_o = 0 (all switches open), sdo_o = 0, cfg_busy_o = 0, cfg_done_o = 0, cfg_err_o = 0.
  - Shift register and bit counter cleared; state IDLE.
  - Synchronizer resets: sck = 0, sdi = 0, cs_n = 1.
  - Reset taking effect mid-SHIFT or mid-BBM aborts immediately; nothing is committed.
- Input sync:
  - Each of sck_i, sdi_i and cs_n_i passes through 2 flops, plus a third flop for edge detect.
  - Edges are acted on at the 3rd clk edge after the pin change.
  - Host requirement: sck high and low times each >= 3 clk periods.
- States: IDLE, SHIFT, BBM, DROP.
- IDLE:
  - Synchronized cs_n falling edge: load shift_q <= cfg_q (readback), count <= 0, go to SHIFT.
  - cs_n rising edge with no transfer in progress: ignored.
- SHIFT:
  - On each synchronized sck rising edge: shift_q <= {shift_q[CFG_BITS-2:0], sdi_sync}.
  - count increments and saturates at CFG_BITS+1.
  - sdo_o = shift_q[CFG_BITS-1]. The first readback bit is valid once the cs_n fall has been detected; it advances after each detected sck rise. The host samples it on the following sck rise.
  - Synchronized cs_n rising edge:
    - If count == CFG_BITS: cfg_q <= 0, bbm_cnt <= 0, go to BBM. This is edge E0.
    - Otherwise (short, long, or zero-length transfer): cfg_err_o <= 1, cfg_o unchanged, go to IDLE.
- BBM:
  - cfg_o = 0 for exactly BBM_CYCLES clock periods, from E0 to E0+BBM_CYCLES.
  - At edge E0+BBM_CYCLES: cfg_q <= shift_q, cfg_done_o <= 1 for one cycle, cfg_err_o <= 0.
  - Next state is IDLE if cs_n_sync is high, else DROP.
  - sck and cs_n edges are ignored while in BBM.
- DROP: wait for the synchronized cs_n rising edge, then cfg_err_o <= 1 and go to IDLE. A transfer started during BBM is never committed.
- Output timing:
  - cfg_busy_o = (state == BBM), registered. It is high exactly for the cycles in which cfg_o is forced to 0 by BBM.
  - cfg_o is always the registered cfg_q; no combinational path from the pins.
- Overflow: bits beyond CFG_BITS keep shifting (the last CFG_BITS bits are retained), but the commit is rejected.
- cfg_err_o clears only on a successful commit or on reset.

Test Plan:
1. Reset: assert rst_n low mid-sim -> cfg_o = 0, sdo_o = 0, cfg_busy_o = 0, cfg_done_o = 0, cfg_err_o = 0 immediately, without waiting for a clk edge.
2. Good write, CFG_BITS = 32, BBM_CYCLES = 4: shift 0xA5C30F81 -> after the cs_n rise, cfg_o = 0 and busy = 1 for exactly 4 cycles, then cfg_o = 0xA5C30F81, a single done pulse, err = 0.
3. Readback: write 0x12345678 after step 2 -> captured sdo_o stream is 0xA5C30F81 MSB first; then cfg_o = 0x12345678.
4. Length errors: 31-bit transfer -> err = 1, cfg_o unchanged, busy never asserts. 33-bit transfer -> same. Following good 32-bit write of 0x0000FFFF -> err = 0, cfg_o = 0x0000FFFF.
5. Overlap: cs_n falls during BBM and a full 32-bit word is shifted -> first commit completes normally; second transfer dropped, err = 1 at its cs_n rise; cfg_o keeps the first word.
6. Reset mid-op: rst_n low during BBM and during SHIFT -> cfg_o = 0 asynchronously, state IDLE; a subsequent clean write of 0xDEADBEEF applies correctly.

Source files
------------

// File: rtl/mosbius_cfg_loader.sv
// Serial configuration front-end for the mini-MOSbius switch matrix.
// A word shifted in over a mode-0 SPI link is applied with a break-before-make gap.
module mosbius_cfg_loader #(
  parameter int CFG_BITS   = 32,
  parameter int BBM_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sck_i,
  input  logic                sdi_i,
  input  logic                cs_n_i,
  output logic                sdo_o,
  output logic [CFG_BITS-1:0] cfg_o,
  output logic                cfg_busy_o,
  output logic                cfg_done_o,
  output logic                cfg_err_o
);

  localparam int CW = $clog2(CFG_BITS + 2);
  localparam int BW = $clog2(BBM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_BITS + 1);
  localparam logic [BW-1:0] BBM_LAST = BW'(BBM_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, BBM, DROP} state_t;

  state_t              state;
  logic [2:0]          sck_sync;
  logic [2:0]          cs_sync;
  logic [1:0]          sdi_sync;
  logic [CFG_BITS-1:0] shift_q;
  logic [CFG_BITS-1:0] cfg_q;
  logic [CW-1:0]       count;
  logic [BW-1:0]       bbm_cnt;

  logic sck_rise;
  logic cs_fall;
  logic cs_rise;

  // Two flops of metastability protection, the third only feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= 3'b000;
      cs_sync  <= 3'b111;
      sdi_sync <= 2'b00;
    end else begin
      sck_sync <= {sck_sync[1:0], sck_i};
      cs_sync  <= {cs_sync[1:0], cs_n_i};
      sdi_sync <= {sdi_sync[0], sdi_i};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_q    <= '0;
      cfg_q      <= '0;
      count      <= '0;
      bbm_cnt    <= '0;
      sdo_o      <= 1'b0;
      cfg_busy_o <= 1'b0;
      cfg_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
    end else begin
      cfg_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_q <= cfg_q;
            sdo_o   <= cfg_q[CFG_BITS-1];
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Chip-select release wins over a coincident clock edge.
          if (cs_rise) begin
            sdo_o <= 1'b0;
            if (count == CNT_FULL) begin
              cfg_q      <= '0;
              bbm_cnt    <= '0;
              cfg_busy_o <= 1'b1;
              state      <= BBM;
            end else begin
              cfg_err_o <= 1'b1;
              state     <= IDLE;
            end
          end else if (sck_rise) begin
            shift_q <= {shift_q[CFG_BITS-2:0], sdi_sync[1]};
            sdo_o   <= shift_q[CFG_BITS-2];
            if (count != CNT_MAX) begin
              count <= count + 1'b1;
            end
          end
        end
        BBM: begin
          if (bbm_cnt == BBM_LAST) begin
            cfg_q      <= shift_q;
            cfg_done_o <= 1'b1;
            cfg_err_o  <= 1'b0;
            cfg_busy_o <= 1'b0;
            state      <= cs_sync[1] ? IDLE : DROP;
          end else begin
            bbm_cnt <= bbm_cnt + 1'b1;
          end
        end
        DROP: begin
          // A transfer that began during the gap is discarded.
          if (cs_rise) begin
            cfg_err_o <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg_o = cfg_q;

endmodule

// File: tb/tb_mosbius_cfg_loader.sv
// Directed bench for mosbius_cfg_loader: writes, readback, length errors,
// overlapping transfers and asynchronous reset.
module tb_mosbius_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        cs_n = 1'b1;
  logic        sdo;
  logic [31:0] cfg;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int busy_total = 0;
  int done_total = 0;
  int viol_total = 0;

  mosbius_cfg_loader #(.CFG_BITS(32), .BBM_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sck_i(sck), .sdi_i(sdi), .cs_n_i(cs_n),
    .sdo_o(sdo), .cfg_o(cfg), .cfg_busy_o(busy), .cfg_done_o(done), .cfg_err_o(err)
  );

  always #5 clk = ~clk;

  // Free-running tallies; tests look at differences across a window.
  always @(negedge clk) begin
    if (busy) begin
      busy_total <= busy_total + 1;
      if (cfg != 32'h0) viol_total <= viol_total + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_shift(input int nbits, input logic [63:0] data, output logic [63:0] rd);
    rd = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = data[i];
      wait_clk(5);
      rd = {rd[62:0], sdo};
      sck = 1'b1;
      wait_clk(5);
      sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int nbits, input logic [63:0] data, output logic [63:0] rd);
    cs_n = 1'b0;
    wait_clk(5);
    spi_shift(nbits, data, rd);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(20);
  endtask

  task automatic write_and_check(input string tag, input int nbits, input logic [63:0] data,
                                 input logic [31:0] exp_cfg, input logic exp_err,
                                 input int exp_busy, input int exp_done,
                                 output logic [63:0] rd);
    int b0, d0, v0;
    b0 = busy_total; d0 = done_total; v0 = viol_total;
    applyStimulus(nbits, data, rd);
    checkOutput({tag, "_cfg"}, 64'(cfg), 64'(exp_cfg));
    checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_total - b0), 64'(exp_busy));
    checkOutput({tag, "_done_pulses"}, 64'(done_total - d0), 64'(exp_done));
    checkOutput({tag, "_open_while_busy"}, 64'(viol_total - v0), 64'd0);
  endtask

  task automatic wait_busy(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [63:0] rd;
    int b0, d0;

    #1;
    checkOutput("rst_cfg", 64'(cfg), 64'd0);
    checkOutput("rst_flags", {60'd0, sdo, busy, done, err}, 64'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    write_and_check("good1", 32, 64'hA5C30F81, 32'hA5C30F81, 1'b0, 4, 1, rd);
    checkOutput("good1_readback", rd, 64'h0);

    write_and_check("good2", 32, 64'h12345678, 32'h12345678, 1'b0, 4, 1, rd);
    checkOutput("good2_readback", rd, 64'hA5C30F81);

    write_and_check("short31", 31, 64'h7FFFFFFF, 32'h12345678, 1'b1, 0, 0, rd);
    write_and_check("long33", 33, 64'h1FFFF0000, 32'h12345678, 1'b1, 0, 0, rd);
    write_and_check("good3", 32, 64'h0000FFFF, 32'h0000FFFF, 1'b0, 4, 1, rd);
    checkOutput("good3_readback", rd, 64'h12345678);
    write_and_check("short31b", 31, 64'h0, 32'h0000FFFF, 1'b1, 0, 0, rd);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cfg", 64'(cfg), 64'd0);
    checkOutput("async_rst_flags", {60'd0, sdo, busy, done, err}, 64'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    write_and_check("good4", 32, 64'h11112222, 32'h11112222, 1'b0, 4, 1, rd);

    b0 = busy_total; d0 = done_total;
    cs_n = 1'b0;
    wait_clk(5);
    spi_shift(32, 64'h55556666, rd);
    wait_clk(5);
    cs_n = 1'b1;
    wait_busy("ovl_busy_seen");
    cs_n = 1'b0;
    wait_clk(5);
    spi_shift(32, 64'h33334444, rd);
    checkOutput("ovl_first_cfg", 64'(cfg), 64'h55556666);
    checkOutput("ovl_first_err", 64'(err), 64'd0);
    wait_clk(5);
    cs_n = 1'b1;
    wait_clk(20);
    checkOutput("ovl_drop_cfg", 64'(cfg), 64'h55556666);
    checkOutput("ovl_drop_err", 64'(err), 64'd1);
    checkOutput("ovl_busy_cycles", 64'(busy_total - b0), 64'd4);
    checkOutput("ovl_done_pulses", 64'(done_total - d0), 64'd1);

    cs_n = 1'b0;
    wait_clk(5);
    spi_shift(32, 64'h0F0F0F0F, rd);
    wait_clk(5);
    cs_n = 1'b1;
    wait_busy("bbm_busy_seen");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("bbm_rst_cfg", 64'(cfg), 64'd0);
    checkOutput("bbm_rst_flags", {60'd0, sdo, busy, done, err}, 64'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    cs_n = 1'b0;
    wait_clk(5);
    spi_shift(10, 64'h3FF, rd);
    #2 rst_n = 1'b0;
    cs_n = 1'b1;
    #1;
    checkOutput("shift_rst_cfg", 64'(cfg), 64'd0);
    checkOutput("shift_rst_flags", {60'd0, sdo, busy, done, err}, 64'd0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    write_and_check("final", 32, 64'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4, 1, rd);
    checkOutput("final_readback", rd, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
